// File: rtl/magma_crypt_core.sv
// magma_crypt_core: iterative GOST R 34.12-2015 Magma encrypt/decrypt engine, ROUNDS_PER_CYCLE rounds per clock.
// Optional MAGMA_ZEROIZE_EN adds a zeroize input that wipes key, state and result.
module magma_crypt_core #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_decrypt,
    input  logic [255:0]  in_key,
    input  logic [63:0]   in_block,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [63:0]   out_block
`ifdef MAGMA_ZEROIZE_EN
    ,
    input  logic          zeroize
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    // Each row packs pi_n with entry v at bits [4v+3:4v].
    localparam logic [63:0] SBOX [8] = '{
        64'h1F307D8E9B5A264C, 64'hF0DB74E1C5A93286,
        64'h069C471EDAF2853B, 64'hB9E35A076F4D128C,
        64'hC24BE390D618A5F7, 64'h0E34187BAC296FD5,
        64'h73AD0B4FC19652E8, 64'h2BC96AF43850DE71
    };

    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
          ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16 || ROUNDS_PER_CYCLE == 32)) begin : g_bad_rpc
        $error("magma_crypt_core: ROUNDS_PER_CYCLE must be one of 1,2,4,8,16,32");
    end

    state_e         state_q, state_d;
    logic [4:0]     ctr_q, ctr_d;
    logic           dec_q, dec_d;
    logic [255:0]   key_q, key_d;
    logic [31:0]    a1_q, a1_d, a0_q, a0_d;
    logic [63:0]    out_q, out_d;
    logic [31:0]    a1_n, a0_n, t;
    logic           zap, clr_on_retire, last;

`ifdef MAGMA_ZEROIZE_EN
    assign zap = zeroize;
    assign clr_on_retire = 1'b1;
`else
    assign zap = 1'b0;
    assign clr_on_retire = 1'b0;
`endif

    function automatic logic [31:0] g_fn(input logic [31:0] a, input logic [31:0] k);
        logic [31:0] x, s;
        x = a + k;
        s = '0;
        for (int n = 0; n < 8; n++)
            s[4*n +: 4] = SBOX[n][{x[4*n +: 4], 2'b00} +: 4];
        return {s[20:0], s[31:21]};
    endfunction

    // Key index runs forward for the first 3 (encrypt) or 1 (decrypt) octets, then backward.
    function automatic logic [31:0] rkey(input logic [255:0] key, input logic [4:0] r, input logic dec);
        logic [2:0] i;
        i = (r < (dec ? 5'd8 : 5'd24)) ? r[2:0] : ~r[2:0];
        return key[{~i, 5'b00000} +: 32];
    endfunction

    // Every round swaps; the final no-swap round is undone by swapping halves at capture.
    always_comb begin
        a1_n = a1_q;
        a0_n = a0_q;
        t = '0;
        for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
            t = a1_n ^ g_fn(a0_n, rkey(key_q, ctr_q + 5'(j), dec_q));
            a1_n = a0_n;
            a0_n = t;
        end
    end

    assign last      = ctr_q == 5'(32 - ROUNDS_PER_CYCLE);
    assign in_ready  = rst_n && !zap && state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign out_block = out_q;

    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        dec_d   = dec_q;
        key_d   = key_q;
        a1_d    = a1_q;
        a0_d    = a0_q;
        out_d   = out_q;
        if (zap) begin
            state_d = IDLE;
            ctr_d   = '0;
            key_d   = '0;
            a1_d    = '0;
            a0_d    = '0;
            out_d   = '0;
        end else if (state_q == IDLE && in_valid) begin
            state_d = RUN;
            dec_d   = in_decrypt;
            key_d   = in_key;
            a1_d    = in_block[63:32];
            a0_d    = in_block[31:0];
        end else if (state_q == RUN) begin
            a1_d    = a1_n;
            a0_d    = a0_n;
            ctr_d   = ctr_q + 5'(ROUNDS_PER_CYCLE);
            state_d = last ? DONE : RUN;
            out_d   = last ? {a0_n, a1_n} : out_q;
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
            key_d   = clr_on_retire ? '0 : key_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ctr_q   <= '0;
            dec_q   <= 1'b0;
            key_q   <= '0;
            a1_q    <= '0;
            a0_q    <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            dec_q   <= dec_d;
            key_q   <= key_d;
            a1_q    <= a1_d;
            a0_q    <= a0_d;
            out_q   <= out_d;
        end
    end
endmodule

// File: tb/tb_magma_crypt_core.sv
// tb_magma_crypt_core: randomized self-checking bench for magma_crypt_core against a behavioural Magma model.
module tb_magma_crypt_core;
    localparam int R = 1;
    localparam int N = 32 / R;
    localparam logic [255:0] KEY = 256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [63:0]  PT  = 64'hfedcba9876543210;
    localparam logic [63:0]  CT  = 64'h4ee901e5c2d8ca3d;
    localparam int SB [8][16] = '{
        '{12, 4, 6, 2, 10, 5, 11, 9, 14, 8, 13, 7, 0, 3, 15, 1},
        '{6, 8, 2, 3, 9, 10, 5, 12, 1, 14, 4, 7, 11, 13, 0, 15},
        '{11, 3, 5, 8, 2, 15, 10, 13, 14, 1, 7, 4, 12, 9, 6, 0},
        '{12, 8, 2, 1, 13, 4, 15, 6, 7, 0, 10, 5, 3, 14, 9, 11},
        '{7, 15, 5, 10, 8, 1, 6, 13, 0, 9, 3, 14, 11, 4, 2, 12},
        '{5, 13, 15, 6, 9, 2, 12, 10, 11, 7, 8, 1, 4, 3, 14, 0},
        '{8, 14, 2, 5, 6, 9, 1, 12, 15, 4, 11, 0, 13, 10, 3, 7},
        '{1, 7, 14, 13, 0, 5, 8, 3, 4, 15, 10, 6, 9, 12, 11, 2}
    };

    logic          clk = 1'b0;
    logic          rst_n, in_valid, in_ready, in_decrypt, out_valid, out_ready;
    logic [255:0]  in_key;
    logic [63:0]   in_block, out_block;
    int            n_checks = 0;
    int            n_fail = 0;
`ifdef MAGMA_ZEROIZE_EN
    logic          zeroize = 1'b0;
`endif

    always #5 clk = ~clk;

    magma_crypt_core #(.ROUNDS_PER_CYCLE(R)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_decrypt(in_decrypt), .in_key(in_key), .in_block(in_block),
        .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block)
`ifdef MAGMA_ZEROIZE_EN
        , .zeroize(zeroize)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_g(input logic [31:0] a, input logic [31:0] k);
        logic [31:0] x, s;
        x = a + k;
        s = '0;
        for (int n = 0; n < 8; n++) s[4*n +: 4] = 4'(SB[n][x[4*n +: 4]]);
        return (s << 11) | (s >> 21);
    endfunction

    // Decryption uses the encryption key schedule in reverse.
    function automatic logic [63:0] ref_magma(input logic [255:0] key, input logic [63:0] blk, input bit dec);
        logic [31:0] k [8];
        logic [31:0] enc [32];
        logic [31:0] a1, a0, t;
        for (int i = 0; i < 8; i++) k[i] = key[255 - 32*i -: 32];
        for (int i = 0; i < 32; i++) enc[i] = (i < 24) ? k[i % 8] : k[7 - i % 8];
        a1 = blk[63:32];
        a0 = blk[31:0];
        for (int i = 0; i < 31; i++) begin
            t = a1 ^ ref_g(a0, dec ? enc[31 - i] : enc[i]);
            a1 = a0;
            a0 = t;
        end
        return {a1 ^ ref_g(a0, dec ? enc[0] : enc[31]), a0};
    endfunction

    // Call at a negedge; returns at the negedge following the accept edge.
    task automatic send(input logic [255:0] key, input logic [63:0] blk, input bit dec);
        int w;
        in_key = key;
        in_block = blk;
        in_decrypt = dec;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("accept_timeout", 64'(w < 100), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int k;
        k = 0;
        check({tag, "_early_valid"}, 64'(out_valid), 64'd0);
        while (!out_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_latency"}, 64'(k), 64'(N));
    endtask

    task automatic retire(input int bp);
        logic [63:0] held;
        held = out_block;
        repeat (bp) begin
            @(negedge clk);
            check("bp_block_stable", out_block, held);
            check("bp_valid_held", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("retire_valid", 64'(out_valid), 64'd0);
        check("retire_in_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic do_op(input string tag, input logic [255:0] key, input logic [63:0] blk,
                         input bit dec, input logic [63:0] exp, input int bp);
        send(key, blk, dec);
        wait_out(tag);
        check({tag, "_block"}, out_block, exp);
        retire(bp);
    endtask

    task automatic watch_silent(input string tag);
        bit seen;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check({tag, "_no_out_valid"}, 64'(seen), 64'd0);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] rk;
        logic [63:0]  rb;
        bit           rd;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_decrypt = 1'b0;
        in_key = '0;
        in_block = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_block", out_block, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        check("model_vector", ref_magma(KEY, PT, 1'b0), CT);

        do_op("enc_vec", KEY, PT, 1'b0, CT, 10);
`ifdef MAGMA_ZEROIZE_EN
        check("retire_key_cleared", 64'(|dut.key_q), 64'd0);
`endif
        do_op("dec_vec", KEY, CT, 1'b1, PT, 0);

        // Back-to-back: second request held on in_valid while the first runs.
        out_ready = 1'b1;
        send(KEY, PT, 1'b0);
        in_block = CT;
        in_decrypt = 1'b1;
        in_valid = 1'b1;
        wait_out("b2b_first");
        check("b2b_first_block", out_block, CT);
        @(negedge clk);
        check("b2b_gap_valid", 64'(out_valid), 64'd0);
        check("b2b_gap_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        check("b2b_second_accepted", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        wait_out("b2b_second");
        check("b2b_second_block", out_block, PT);
        @(negedge clk);
        out_ready = 1'b0;
        check("b2b_idle", 64'(in_ready), 64'd1);

        // Reset in the middle of a run.
        send(KEY, PT, 1'b0);
        repeat (10 / R) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        repeat (3) begin
            @(negedge clk);
            check("midrst_out_valid", 64'(out_valid), 64'd0);
        end
        rst_n = 1'b1;
        watch_silent("midrst");
        do_op("after_rst", KEY, PT, 1'b0, CT, 1);

`ifdef MAGMA_ZEROIZE_EN
        send(KEY, PT, 1'b0);
        repeat (16 / R) @(negedge clk);
        zeroize = 1'b1;
        #1;
        check("zap_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        zeroize = 1'b0;
        check("zap_idle", 64'(in_ready), 64'd1);
        check("zap_out_block", out_block, 64'd0);
        check("zap_key", 64'(|dut.key_q), 64'd0);
        watch_silent("zap");
        do_op("after_zap", KEY, CT, 1'b1, PT, 0);
`endif

        for (int i = 0; i < 12; i++) begin
            for (int w = 0; w < 8; w++) rk[32*w +: 32] = $urandom;
            rb = {$urandom, $urandom};
            rd = 1'($urandom_range(0, 1));
            do_op("rand", rk, rb, rd, ref_magma(rk, rb, rd), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
